// File: rtl/calc_pkg.sv
// Shared definitions for the calculator key sequencer: key codes, ALU op
// encodings, FSM states and result limits.
package calc_pkg;

   localparam logic [3:0] KEY_ADD = 4'd10;
   localparam logic [3:0] KEY_SUB = 4'd11;
   localparam logic [3:0] KEY_MUL = 4'd12;
   localparam logic [3:0] KEY_EQ  = 4'd13;
   localparam logic [3:0] KEY_CE  = 4'd14;
   localparam logic [3:0] KEY_AC  = 4'd15;

   localparam logic [1:0] OP_ADD = 2'b00;
   localparam logic [1:0] OP_SUB = 2'b01;
   localparam logic [1:0] OP_MUL = 2'b10;

   localparam int RES_MAX_DEFAULT = 9999;
   localparam int ENTRY_W         = 10;

   typedef enum logic [2:0] {
      ENTER_A,
      OP_WAIT,
      ENTER_B,
      CALC,
      SHOW,
      ERR
   } state_t;

   function automatic logic is_digit(input logic [3:0] k);
      return k <= 4'd9;
   endfunction

   function automatic logic is_op(input logic [3:0] k);
      return (k == KEY_ADD) || (k == KEY_SUB) || (k == KEY_MUL);
   endfunction

   function automatic logic [1:0] key_to_op(input logic [3:0] k);
      case (k)
         KEY_SUB: return OP_SUB;
         KEY_MUL: return OP_MUL;
         default: return OP_ADD;
      endcase
   endfunction

endpackage

// File: rtl/calc_digit_entry.sv
// BCD entry shifter: holds up to DIGITS decimal digits, newest digit least
// significant, and presents both the current and next binary value.
module calc_digit_entry
   import calc_pkg::*;
#(
   parameter int DIGITS = 3,
   parameter int VAL_W  = ENTRY_W
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             clear,
   input  logic             shift,
   input  logic             load_first,
   input  logic [3:0]       digit,
   output logic [VAL_W-1:0] value,
   output logic [VAL_W-1:0] value_next
);

   localparam int CNT_W = $clog2(DIGITS + 1);

   logic [4*DIGITS-1:0] digs, digs_n;
   logic [CNT_W-1:0]    cnt, cnt_n;

   function automatic logic [VAL_W-1:0] to_bin(input logic [4*DIGITS-1:0] d);
      logic [VAL_W-1:0] acc;
      acc = '0;
      for (int i = DIGITS - 1; i >= 0; i--) begin
         acc = (acc * VAL_W'(10)) + VAL_W'(d[4*i +: 4]);
      end
      return acc;
   endfunction

   always_comb begin
      digs_n = digs;
      cnt_n  = cnt;
      if (clear) begin
         digs_n = '0;
         cnt_n  = '0;
      end else if (load_first) begin
         digs_n      = '0;
         digs_n[3:0] = digit;
         cnt_n       = CNT_W'(1);
      end else if (shift && (cnt < CNT_W'(DIGITS))) begin
         // A full entry saturates: extra digits are dropped rather than wrapped.
         digs_n = {digs[4*(DIGITS-1)-1:0], digit};
         cnt_n  = cnt + CNT_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         digs <= '0;
         cnt  <= '0;
      end else begin
         digs <= digs_n;
         cnt  <= cnt_n;
      end
   end

   assign value      = to_bin(digs);
   assign value_next = to_bin(digs_n);

endmodule

// File: rtl/calc_key_sequencer.sv
// Calculator keypad sequencer: builds operands, runs one ALU operation per
// '=' and drives the display. Optional chaining via CALC_CHAIN_EN.
//
//   state   | meaning
//   --------+-----------------------------------------------
//   ENTER_A | entering first operand
//   OP_WAIT | operator chosen, waiting for first B digit
//   ENTER_B | entering second operand
//   CALC    | ALU running, keys dropped
//   SHOW    | result displayed
//   ERR     | error displayed, only CE/AC leave
module calc_key_sequencer
   import calc_pkg::*;
#(
   parameter int DIGITS  = 3,
   parameter int RES_MAX = RES_MAX_DEFAULT
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        key_valid,
   input  logic [3:0]  key_code,
   output logic        alu_start,
   output logic [1:0]  alu_op,
   output logic [13:0] alu_a,
   output logic [9:0]  alu_b,
   input  logic        alu_done,
   input  logic [19:0] alu_result,
   output logic [13:0] disp_value,
   output logic        disp_err,
   output logic        busy
);

   localparam logic [19:0] RES_LIMIT = 20'(RES_MAX);

   state_t       state, state_n;
   logic [13:0]  a_reg, a_n;
   logic [9:0]   b_reg, b_n;
   logic [1:0]   op_reg, op_n;
   logic [13:0]  result, result_n;
   logic         start_n, err_n, busy_n;
   logic [13:0]  disp_n;
   logic         ent_clear, ent_shift, ent_load, full_clear;
   logic [ENTRY_W-1:0] ent_value, ent_next;
   logic [13:0]  ent_ext;
   logic         chain_key;

`ifdef CALC_CHAIN_EN
   logic         pend, pend_n;
   logic [1:0]   pend_op, pend_op_n;
   assign chain_key = is_op(key_code);
`else
   assign chain_key = 1'b0;
`endif

   assign ent_ext = {{(14 - ENTRY_W){1'b0}}, ent_value};

   calc_digit_entry #(
      .DIGITS (DIGITS),
      .VAL_W  (ENTRY_W)
   ) u_entry (
      .clk        (clk),
      .reset      (reset),
      .clear      (ent_clear),
      .shift      (ent_shift),
      .load_first (ent_load),
      .digit      (key_code),
      .value      (ent_value),
      .value_next (ent_next)
   );

   always_comb begin
      state_n    = state;
      a_n        = a_reg;
      b_n        = b_reg;
      op_n       = op_reg;
      result_n   = result;
      start_n    = 1'b0;
      ent_clear  = 1'b0;
      ent_shift  = 1'b0;
      ent_load   = 1'b0;
      full_clear = 1'b0;
`ifdef CALC_CHAIN_EN
      pend_n    = pend;
      pend_op_n = pend_op;
`endif

      if (state == CALC) begin
         if (alu_done) begin
            if (alu_result > RES_LIMIT) begin
               state_n = ERR;
`ifdef CALC_CHAIN_EN
               pend_n = 1'b0;
`endif
            end else begin
               result_n = alu_result[13:0];
               state_n  = SHOW;
`ifdef CALC_CHAIN_EN
               if (pend) begin
                  state_n = OP_WAIT;
                  a_n     = alu_result[13:0];
                  op_n    = pend_op;
                  pend_n  = 1'b0;
               end
`endif
            end
         end
      end else if (key_valid) begin
         if (key_code == KEY_AC) begin
            full_clear = 1'b1;
         end else begin
            case (state)
               ENTER_A: begin
                  if (is_digit(key_code)) begin
                     ent_shift = 1'b1;
                  end else if (is_op(key_code)) begin
                     a_n       = ent_ext;
                     op_n      = key_to_op(key_code);
                     ent_clear = 1'b1;
                     state_n   = OP_WAIT;
                  end else if (key_code == KEY_CE) begin
                     ent_clear = 1'b1;
                  end
               end
               OP_WAIT: begin
                  if (is_op(key_code)) begin
                     op_n = key_to_op(key_code);
                  end else if (is_digit(key_code)) begin
                     ent_load = 1'b1;
                     state_n  = ENTER_B;
                  end
               end
               ENTER_B: begin
                  if (is_digit(key_code)) begin
                     ent_shift = 1'b1;
                  end else if (key_code == KEY_CE) begin
                     ent_clear = 1'b1;
                  end else if ((key_code == KEY_EQ) || chain_key) begin
                     b_n = ent_value;
                     // Subtraction below zero is refused before the ALU is touched.
                     if ((op_reg == OP_SUB) && (ent_ext > a_reg)) begin
                        state_n = ERR;
                     end else begin
                        state_n = CALC;
                        start_n = 1'b1;
`ifdef CALC_CHAIN_EN
                        if (chain_key) begin
                           pend_n    = 1'b1;
                           pend_op_n = key_to_op(key_code);
                        end
`endif
                     end
                  end
               end
               SHOW: begin
                  if (is_digit(key_code)) begin
                     ent_load = 1'b1;
                     state_n  = ENTER_A;
                  end else if (is_op(key_code)) begin
                     a_n       = result;
                     op_n      = key_to_op(key_code);
                     ent_clear = 1'b1;
                     state_n   = OP_WAIT;
                  end else if (key_code == KEY_EQ) begin
                     a_n     = result;
                     state_n = CALC;
                     start_n = 1'b1;
                  end else if (key_code == KEY_CE) begin
                     full_clear = 1'b1;
                  end
               end
               ERR: begin
                  if (key_code == KEY_CE) full_clear = 1'b1;
               end
               default: ;
            endcase
         end
      end

      if (full_clear) begin
         state_n   = ENTER_A;
         a_n       = '0;
         b_n       = '0;
         op_n      = OP_ADD;
         result_n  = '0;
         start_n   = 1'b0;
         ent_clear = 1'b1;
         ent_shift = 1'b0;
         ent_load  = 1'b0;
`ifdef CALC_CHAIN_EN
         pend_n    = 1'b0;
         pend_op_n = OP_ADD;
`endif
      end

      // Display registers track what the next state will present.
      case (state_n)
         ENTER_A, ENTER_B: disp_n = {{(14 - ENTRY_W){1'b0}}, ent_next};
         OP_WAIT:          disp_n = a_n;
         CALC:             disp_n = disp_value;
         SHOW:             disp_n = result_n;
         default:          disp_n = '0;
      endcase
      err_n  = (state_n == ERR);
      busy_n = (state_n == CALC);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= ENTER_A;
         a_reg      <= '0;
         b_reg      <= '0;
         op_reg     <= OP_ADD;
         result     <= '0;
         alu_start  <= 1'b0;
         disp_value <= '0;
         disp_err   <= 1'b0;
         busy       <= 1'b0;
`ifdef CALC_CHAIN_EN
         pend       <= 1'b0;
         pend_op    <= OP_ADD;
`endif
      end else begin
         state      <= state_n;
         a_reg      <= a_n;
         b_reg      <= b_n;
         op_reg     <= op_n;
         result     <= result_n;
         alu_start  <= start_n;
         disp_value <= disp_n;
         disp_err   <= err_n;
         busy       <= busy_n;
`ifdef CALC_CHAIN_EN
         pend       <= pend_n;
         pend_op    <= pend_op_n;
`endif
      end
   end

   assign alu_a  = a_reg;
   assign alu_b  = b_reg;
   assign alu_op = op_reg;

endmodule

// File: tb/tb_calc_key_sequencer.sv
// Self-checking bench for calc_key_sequencer: directed vector table, corner
// sequences and randomized keys against a behavioural calculator model.
module tb_calc_key_sequencer;

   logic        clk = 1'b0;
   logic        reset;
   logic        key_valid;
   logic [3:0]  key_code;
   logic        alu_start;
   logic [1:0]  alu_op;
   logic [13:0] alu_a;
   logic [9:0]  alu_b;
   logic        alu_done;
   logic [19:0] alu_result;
   logic [13:0] disp_value;
   logic        disp_err;
   logic        busy;

   calc_key_sequencer dut (
      .clk        (clk),
      .reset      (reset),
      .key_valid  (key_valid),
      .key_code   (key_code),
      .alu_start  (alu_start),
      .alu_op     (alu_op),
      .alu_a      (alu_a),
      .alu_b      (alu_b),
      .alu_done   (alu_done),
      .alu_result (alu_result),
      .disp_value (disp_value),
      .disp_err   (disp_err),
      .busy       (busy)
   );

   always #5 clk = ~clk;

   int checks   = 0;
   int failures = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic press(input logic [3:0] k);
      key_valid = 1'b1;
      key_code  = k;
      tick();
      key_valid = 1'b0;
      key_code  = 4'd0;
   endtask

   task automatic done_pulse(input logic [19:0] r);
      alu_done   = 1'b1;
      alu_result = r;
      tick();
      alu_done   = 1'b0;
      alu_result = '0;
   endtask

   // External ALU behaviour: 20-bit unsigned, wrapping.
   function automatic logic [19:0] alu_calc(input int a, input int b, input int op);
      case (op)
         0:       return 20'(a + b);
         1:       return 20'(a - b);
         default: return 20'(a * b);
      endcase
   endfunction

   // ---------------- behavioural model ----------------
   localparam int M_A = 0, M_W = 1, M_B = 2, M_C = 3, M_S = 4, M_E = 5;
   int m_mode, m_ent, m_cnt, m_a, m_b, m_op, m_res, m_disp, m_pend;

   task automatic m_clear();
      m_mode = M_A; m_ent = 0; m_cnt = 0; m_a = 0; m_b = 0;
      m_op = 0; m_res = 0; m_disp = 0; m_pend = -1;
   endtask

   task automatic m_update_disp();
      case (m_mode)
         M_A, M_B: m_disp = m_ent;
         M_W:      m_disp = m_a;
         M_S:      m_disp = m_res;
         M_E:      m_disp = 0;
         default:  ;
      endcase
   endtask

   task automatic m_equals(input int pend_op);
      m_b = m_ent;
      if (m_op == 1 && m_b > m_a) begin
         m_mode = M_E;
         m_pend = -1;
      end else begin
         m_mode = M_C;
         m_pend = pend_op;
      end
   endtask

   task automatic m_key(input int k, output bit started);
      bit digit, oper;
      started = 1'b0;
      digit = (k <= 9);
      oper  = (k >= 10 && k <= 12);
      if (m_mode == M_C) return;
      if (k == 15) begin
         m_clear();
         return;
      end
      case (m_mode)
         M_A: begin
            if (digit) begin
               if (m_cnt < 3) begin m_ent = m_ent * 10 + k; m_cnt++; end
            end else if (oper) begin
               m_a = m_ent; m_op = k - 10; m_ent = 0; m_cnt = 0; m_mode = M_W;
            end else if (k == 14) begin
               m_ent = 0; m_cnt = 0;
            end
         end
         M_W: begin
            if (oper) m_op = k - 10;
            else if (digit) begin m_ent = k; m_cnt = 1; m_mode = M_B; end
         end
         M_B: begin
            if (digit) begin
               if (m_cnt < 3) begin m_ent = m_ent * 10 + k; m_cnt++; end
            end else if (k == 14) begin
               m_ent = 0; m_cnt = 0;
            end else if (k == 13) begin
               m_equals(-1);
`ifdef CALC_CHAIN_EN
            end else if (oper) begin
               m_equals(k - 10);
`endif
            end
         end
         M_S: begin
            if (digit) begin m_ent = k; m_cnt = 1; m_mode = M_A; end
            else if (oper) begin m_a = m_res; m_op = k - 10; m_ent = 0; m_cnt = 0; m_mode = M_W; end
            else if (k == 13) begin m_a = m_res; m_mode = M_C; end
            else if (k == 14) m_clear();
         end
         M_E: if (k == 14) m_clear();
         default: ;
      endcase
      started = (m_mode == M_C);
      m_update_disp();
   endtask

   task automatic m_done(input logic [19:0] r);
      if (r > 20'd9999) begin
         m_mode = M_E;
         m_pend = -1;
      end else begin
         m_res = int'(r);
         if (m_pend >= 0) begin
            m_a = m_res; m_op = m_pend; m_pend = -1; m_mode = M_W;
         end else begin
            m_mode = M_S;
         end
      end
      m_update_disp();
   endtask

   // ---------------- directed vector table ----------------
   typedef struct {
      logic [3:0] code;
      int disp; bit err; bit busy; bit start;
      int a; int b; int op; int lat;
      int rdisp; bit rerr;
   } vec_t;

   vec_t vq[$];

   function automatic vec_t kv(input int code, input int disp, input bit err);
      vec_t v;
      v.code = 4'(code); v.disp = disp; v.err = err; v.busy = 1'b0; v.start = 1'b0;
      v.a = 0; v.b = 0; v.op = 0; v.lat = 0; v.rdisp = 0; v.rerr = 1'b0;
      return v;
   endfunction

   function automatic vec_t ev(input int code, input int disp, input int a, input int b,
                               input int op, input int lat, input int rdisp, input bit rerr);
      vec_t v;
      v.code = 4'(code); v.disp = disp; v.err = 1'b0; v.busy = 1'b1; v.start = 1'b1;
      v.a = a; v.b = b; v.op = op; v.lat = lat; v.rdisp = rdisp; v.rerr = rerr;
      return v;
   endfunction

   initial begin
      bit started;
      int lat, k;
      logic [19:0] r;

      reset = 1'b1; key_valid = 1'b0; key_code = 4'd0; alu_done = 1'b0; alu_result = '0;
      repeat (3) tick();
      reset = 1'b0;
      tick();

      chk("reset_disp", disp_value, 0);
      chk("reset_err", disp_err, 0);
      chk("reset_busy", busy, 0);
      chk("reset_start", alu_start, 0);
      chk("reset_a", alu_a, 0);
      chk("reset_b", alu_b, 0);
      chk("reset_op", alu_op, 0);

      // entry saturation, add, repeat '=', chaining from SHOW
      vq.push_back(kv(1, 1, 0));   vq.push_back(kv(2, 12, 0));
      vq.push_back(kv(3, 123, 0)); vq.push_back(kv(4, 123, 0));
      vq.push_back(kv(10, 123, 0)); vq.push_back(kv(4, 4, 0));
      vq.push_back(kv(5, 45, 0));
      vq.push_back(ev(13, 45, 123, 45, 0, 3, 168, 0));
      vq.push_back(ev(13, 168, 168, 45, 0, 2, 213, 0));
      vq.push_back(kv(10, 213, 0)); vq.push_back(kv(7, 7, 0));
      vq.push_back(ev(13, 7, 213, 7, 0, 1, 220, 0));
      vq.push_back(kv(15, 0, 0));
      // negative subtraction refused, ERR sticky, CE recovers
      vq.push_back(kv(5, 5, 0)); vq.push_back(kv(11, 5, 0)); vq.push_back(kv(9, 9, 0));
      vq.push_back(kv(13, 0, 1)); vq.push_back(kv(7, 0, 1)); vq.push_back(kv(14, 0, 0));
      // overflow
      vq.push_back(kv(9, 9, 0)); vq.push_back(kv(9, 99, 0)); vq.push_back(kv(9, 999, 0));
      vq.push_back(kv(12, 999, 0));
      vq.push_back(kv(9, 9, 0)); vq.push_back(kv(9, 99, 0)); vq.push_back(kv(9, 999, 0));
      vq.push_back(ev(13, 999, 999, 999, 2, 3, 0, 1));
      vq.push_back(kv(15, 0, 0));
      // CE in ENTER_A, '=' ignored in ENTER_A/OP_WAIT, operator replacement
      vq.push_back(kv(4, 4, 0)); vq.push_back(kv(2, 42, 0)); vq.push_back(kv(14, 0, 0));
      vq.push_back(kv(5, 5, 0)); vq.push_back(kv(13, 5, 0)); vq.push_back(kv(10, 5, 0));
      vq.push_back(kv(11, 5, 0)); vq.push_back(kv(13, 5, 0)); vq.push_back(kv(3, 3, 0));
      vq.push_back(ev(13, 3, 5, 3, 1, 1, 2, 0));
      vq.push_back(kv(8, 8, 0)); vq.push_back(kv(15, 0, 0));
      // operator key in ENTER_B
      vq.push_back(kv(2, 2, 0)); vq.push_back(kv(10, 2, 0)); vq.push_back(kv(3, 3, 0));
`ifdef CALC_CHAIN_EN
      vq.push_back(ev(12, 3, 2, 3, 0, 2, 5, 0));
      vq.push_back(kv(4, 4, 0));
      vq.push_back(ev(13, 4, 5, 4, 2, 1, 20, 0));
`else
      vq.push_back(kv(12, 3, 0));
      vq.push_back(ev(13, 3, 2, 3, 0, 2, 5, 0));
`endif
      vq.push_back(kv(15, 0, 0));

      foreach (vq[i]) begin
         press(vq[i].code);
         chk($sformatf("v%0d_disp", i), disp_value, vq[i].disp);
         chk($sformatf("v%0d_err", i), disp_err, vq[i].err);
         chk($sformatf("v%0d_busy", i), busy, vq[i].busy);
         chk($sformatf("v%0d_start", i), alu_start, vq[i].start);
         if (vq[i].start) begin
            chk($sformatf("v%0d_alu_a", i), alu_a, vq[i].a);
            chk($sformatf("v%0d_alu_b", i), alu_b, vq[i].b);
            chk($sformatf("v%0d_alu_op", i), alu_op, vq[i].op);
            for (int j = 0; j < vq[i].lat; j++) begin
               tick();
               chk($sformatf("v%0d_start_once", i), alu_start, 0);
               chk($sformatf("v%0d_busy_hold", i), busy, 1);
               chk($sformatf("v%0d_a_hold", i), alu_a, vq[i].a);
            end
            done_pulse(alu_calc(vq[i].a, vq[i].b, vq[i].op));
            chk($sformatf("v%0d_res_disp", i), disp_value, vq[i].rdisp);
            chk($sformatf("v%0d_res_err", i), disp_err, vq[i].rerr);
            chk($sformatf("v%0d_res_busy", i), busy, 0);
         end
      end

      // digit during CALC dropped
      press(4'd1); press(4'd10); press(4'd2); press(4'd13);
      chk("drop_start", alu_start, 1);
      tick();
      press(4'd7);
      chk("drop_busy", busy, 1);
      chk("drop_disp_hold", disp_value, 2);
      done_pulse(20'd3);
      chk("drop_result", disp_value, 3);
      chk("drop_busy_end", busy, 0);
      // spurious done outside CALC
      press(4'd15); press(4'd6);
      done_pulse(20'd77);
      chk("spur_disp", disp_value, 6);
      chk("spur_err", disp_err, 0);
      chk("spur_busy", busy, 0);
      press(4'd1);
      chk("spur_entry_ok", disp_value, 61);
      // reset mid-CALC
      press(4'd15); press(4'd1); press(4'd10); press(4'd1); press(4'd13);
      chk("rst_calc_busy", busy, 1);
      tick();
      reset = 1'b1;
      tick();
      reset = 1'b0;
      chk("rst_busy", busy, 0);
      chk("rst_disp", disp_value, 0);
      chk("rst_start", alu_start, 0);
      chk("rst_a", alu_a, 0);
      tick();
      done_pulse(20'd2);
      chk("late_done_disp", disp_value, 0);
      chk("late_done_busy", busy, 0);
      press(4'd4);
      chk("late_done_entry", disp_value, 4);

      // randomized keys against the model
      press(4'd15);
      m_clear();
      for (int n = 0; n < 400; n++) begin
         k = $urandom_range(0, 99);
         if (k < 60)      k = $urandom_range(0, 9);
         else if (k < 75) k = $urandom_range(10, 12);
         else if (k < 88) k = 13;
         else if (k < 95) k = 14;
         else             k = 15;
         press(4'(k));
         m_key(k, started);
         chk("rnd_disp", disp_value, m_disp);
         chk("rnd_err", disp_err, (m_mode == M_E));
         chk("rnd_busy", busy, (m_mode == M_C));
         chk("rnd_start", alu_start, started);
         if (m_mode == M_C) begin
            chk("rnd_alu_a", alu_a, m_a);
            chk("rnd_alu_b", alu_b, m_b);
            chk("rnd_alu_op", alu_op, m_op);
            lat = $urandom_range(1, 4);
            for (int j = 0; j < lat; j++) begin
               if ($urandom_range(0, 3) == 0) press(4'($urandom_range(0, 15)));
               else tick();
            end
            chk("rnd_calc_busy", busy, 1);
            r = alu_calc(m_a, m_b, m_op);
            done_pulse(r);
            m_done(r);
            chk("rnd_res_disp", disp_value, m_disp);
            chk("rnd_res_err", disp_err, (m_mode == M_E));
            chk("rnd_res_busy", busy, 0);
         end
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
